// File: rtl/sdram_phase_autotune_pkg.sv
// Shared types and helpers for the SDRAM clock phase auto-tuner.
package sdram_phase_pkg;

    // Width of the phase offset, best phase and step-count fields.
    localparam int unsigned PHASE_W = 8;

    typedef enum logic [3:0] {
        IDLE,
        STEP_SETUP,
        STEP_PULSE,
        STEP_HOLD,
        SETTLE,
        DWELL,
        RECORD,
        SCAN,
        ALIGN,
        DONE
    } state_t;

    // Bits needed for a counter that runs 0..n-1, never less than 1.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sdram_phase_autotune_if.sv
// Control, mem_tester counter and PLL phase signals of the auto-tuner.
interface sdram_phase_autotune_if
    import sdram_phase_pkg::*;
#(
    parameter int unsigned C_steps = 8
);
    logic                   start;
    logic [31:0]            passcount;
    logic [31:0]            failcount;
    logic                   phasedir;
    logic                   phasestep;
    logic                   phaseloadreg;
    logic [PHASE_W-1:0]     phase;
    logic [C_steps-1:0]     pass_map;
    logic [PHASE_W-1:0]     best_phase;
    logic [PHASE_W:0]       window_len;
    logic                   busy;
    logic                   done;
    logic                   nopass;

    // Requester / environment side.
    modport master (
        output start, passcount, failcount,
        input  phasedir, phasestep, phaseloadreg, phase, pass_map,
               best_phase, window_len, busy, done, nopass
    );

    // Auto-tuner side.
    modport slave (
        input  start, passcount, failcount,
        output phasedir, phasestep, phaseloadreg, phase, pass_map,
               best_phase, window_len, busy, done, nopass
    );
endinterface

// File: rtl/sdram_phase_autotune_phase_stepper.sv
// Issues 'count' forward PLL phase steps, each as setup-low / pulse-high /
// hold-low segments of C_pulse_cycles each. step_done marks each step.
module phase_stepper
    import sdram_phase_pkg::*;
#(
    parameter int unsigned C_pulse_cycles = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req,
    input  logic [PHASE_W-1:0] count,
    output logic               phasestep,
    output logic               phasedir,
    output logic               busy,
    output logic               step_done
);

    localparam int unsigned   PW    = cnt_width(C_pulse_cycles);
    localparam logic [PW-1:0] PLAST = PW'(C_pulse_cycles - 1);

    state_t             state_q, state_d;
    logic [PW-1:0]      cnt_q, cnt_d;
    logic [PHASE_W-1:0] rem_q, rem_d;
    logic               phasestep_q, phasestep_d;

    // State, segment counter, remaining steps and registered pulse output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            phasestep_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            phasestep_q <= phasestep_d;
        end
    end

    // Segment sequencing: SETUP -> PULSE -> HOLD, repeated per step.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        step_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (req && (count != '0)) begin
                    rem_d   = count;
                    cnt_d   = '0;
                    state_d = STEP_SETUP;
                end
            end
            STEP_SETUP: begin
                if (cnt_q == PLAST) begin
                    cnt_d   = '0;
                    state_d = STEP_PULSE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STEP_PULSE: begin
                if (cnt_q == PLAST) begin
                    cnt_d   = '0;
                    state_d = STEP_HOLD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STEP_HOLD: begin
                if (cnt_q == PLAST) begin
                    cnt_d     = '0;
                    step_done = 1'b1;
                    if (rem_q == PHASE_W'(1)) begin
                        state_d = IDLE;
                    end else begin
                        rem_d   = rem_q - PHASE_W'(1);
                        state_d = STEP_SETUP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        phasestep_d = (state_d == STEP_PULSE);
    end

    assign phasestep = phasestep_q;
    assign phasedir  = 1'b0;
    assign busy      = (state_q != IDLE);

endmodule

// File: rtl/sdram_phase_autotune.sv
// SDRAM chip-clock phase auto-tuner: sweeps the PLL phase one full turn,
// builds a pass map from mem_tester counters, finds the centre of the widest
// circular passing run and steps the PLL there.
// Latency, in clk edges from the edge sampling start to the edge raising done:
//   C_steps*(C_settle_cycles + C_dwell_cycles + 2 + 3*C_pulse_cycles)
//   + 2*C_steps + (n == 0 ? 1 : 3*C_pulse_cycles*n + 2), n = align steps.
module sdram_phase_autotune
    import sdram_phase_pkg::*;
#(
    parameter int unsigned C_steps         = 8,
    parameter int unsigned C_settle_cycles = 1024,
    parameter int unsigned C_dwell_cycles  = 65536,
    parameter int unsigned C_pulse_cycles  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    sdram_phase_autotune_if.slave bus
);

    localparam int unsigned        IW    = $clog2(C_steps);
    localparam int unsigned        TMAX  = (C_settle_cycles > C_dwell_cycles) ?
                                           C_settle_cycles : C_dwell_cycles;
    localparam int unsigned        TW    = cnt_width(TMAX);
    localparam logic [TW-1:0]      SLAST = TW'(C_settle_cycles - 1);
    localparam logic [TW-1:0]      DLAST = TW'(C_dwell_cycles - 1);
    localparam logic [PHASE_W-1:0] PMASK = PHASE_W'(C_steps - 1);
    localparam logic [PHASE_W:0]   NSTEP = (PHASE_W + 1)'(C_steps);
    localparam logic [IW:0]        KLAST = '1;

    state_t             state_q, state_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [PHASE_W:0]   meas_q, meas_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [C_steps-1:0] pass_map_q, pass_map_d;
    logic [31:0]        f0_q, f0_d, p0_q, p0_d;
    logic [IW:0]        k_q, k_d;
    logic [PHASE_W:0]   run_q, run_d, blen_q, blen_d;
    logic [IW-1:0]      run_start_q, run_start_d, bstart_q, bstart_d;
    logic [PHASE_W-1:0] best_phase_q, best_phase_d;
    logic [PHASE_W:0]   window_len_q, window_len_d;
    logic               nopass_q, nopass_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               scan_bit;
    logic [PHASE_W:0]   run_new;
    logic [IW-1:0]      start_new;

    logic               stp_req, stp_busy, stp_done, stp_phasestep, stp_phasedir;
    logic [PHASE_W-1:0] stp_count;

    phase_stepper #(
        .C_pulse_cycles(C_pulse_cycles)
    ) u_stepper (
        .clk      (clk),
        .reset    (reset),
        .req      (stp_req),
        .count    (stp_count),
        .phasestep(stp_phasestep),
        .phasedir (stp_phasedir),
        .busy     (stp_busy),
        .step_done(stp_done)
    );

    // Sweep controller state and result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            meas_q       <= '0;
            phase_q      <= '0;
            pass_map_q   <= '0;
            f0_q         <= '0;
            p0_q         <= '0;
            k_q          <= '0;
            run_q        <= '0;
            run_start_q  <= '0;
            blen_q       <= '0;
            bstart_q     <= '0;
            best_phase_q <= '0;
            window_len_q <= '0;
            nopass_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            meas_q       <= meas_d;
            phase_q      <= phase_d;
            pass_map_q   <= pass_map_d;
            f0_q         <= f0_d;
            p0_q         <= p0_d;
            k_q          <= k_d;
            run_q        <= run_d;
            run_start_q  <= run_start_d;
            blen_q       <= blen_d;
            bstart_q     <= bstart_d;
            best_phase_q <= best_phase_d;
            window_len_q <= window_len_d;
            nopass_q     <= nopass_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    // Next-state: measure/step sweep, circular window scan, align, done.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        meas_d       = meas_q;
        phase_d      = phase_q;
        pass_map_d   = pass_map_q;
        f0_d         = f0_q;
        p0_d         = p0_q;
        k_d          = k_q;
        run_d        = run_q;
        run_start_d  = run_start_q;
        blen_d       = blen_q;
        bstart_d     = bstart_q;
        best_phase_d = best_phase_q;
        window_len_d = window_len_q;
        nopass_d     = nopass_q;
        stp_req      = 1'b0;
        stp_count    = PHASE_W'(1);

        // Two laps over the map so runs crossing phase 0 are seen whole.
        scan_bit  = pass_map_q[k_q[IW-1:0]];
        run_new   = (run_q >= NSTEP) ? NSTEP : run_q + 1'b1;
        start_new = (run_q == '0) ? k_q[IW-1:0] : run_start_q;

        if (stp_done) begin
            phase_d = (phase_q + PHASE_W'(1)) & PMASK;
        end

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    pass_map_d = '0;
                    timer_d    = '0;
                    meas_d     = '0;
                    state_d    = SETTLE;
                end
            end
            SETTLE: begin
                if (timer_q == SLAST) begin
                    timer_d = '0;
                    f0_d    = bus.failcount;
                    p0_d    = bus.passcount;
                    state_d = DWELL;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            DWELL: begin
                if (timer_q == DLAST) begin
                    timer_d = '0;
                    state_d = RECORD;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            RECORD: begin
                pass_map_d[phase_q[IW-1:0]] = (bus.failcount == f0_q) &&
                                              (bus.passcount != p0_q);
                meas_d  = meas_q + 1'b1;
                stp_req = 1'b1;
                state_d = STEP_SETUP;
            end
            STEP_SETUP: begin
                // Sweep step in flight; leave once the stepper is idle again.
                if (!stp_busy) begin
                    if (meas_q == NSTEP) begin
                        k_d         = '0;
                        run_d       = '0;
                        run_start_d = '0;
                        blen_d      = '0;
                        bstart_d    = '0;
                        state_d     = SCAN;
                    end else begin
                        timer_d = '0;
                        state_d = SETTLE;
                    end
                end
            end
            SCAN: begin
                if (scan_bit) begin
                    run_d       = run_new;
                    run_start_d = start_new;
                    if (run_new > blen_q) begin
                        blen_d   = run_new;
                        bstart_d = start_new;
                    end
                end else begin
                    run_d = '0;
                end
                if (k_q == KLAST) begin
                    window_len_d = blen_d;
                    best_phase_d = (PHASE_W'(bstart_d) + blen_d[PHASE_W:1]) & PMASK;
                    nopass_d     = (blen_d == '0);
                    state_d      = ALIGN;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            ALIGN: begin
                if (!stp_busy) begin
                    if (phase_q == best_phase_q) begin
                        state_d = DONE;
                    end else begin
                        stp_req   = 1'b1;
                        stp_count = (best_phase_q - phase_q) & PMASK;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE) && (state_d != DONE);
        done_d = (state_d == DONE);
    end

    assign bus.phasestep    = stp_phasestep;
    assign bus.phasedir     = stp_phasedir;
    assign bus.phaseloadreg = 1'b0;
    assign bus.phase        = phase_q;
    assign bus.pass_map     = pass_map_q;
    assign bus.best_phase   = best_phase_q;
    assign bus.window_len   = window_len_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.nopass       = nopass_q;

endmodule

// File: tb/tb_sdram_phase_autotune.sv
// Directed bench for sdram_phase_autotune with a simple mem_tester model.
module tb_sdram_phase_autotune;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sdram_phase_autotune_if #(.C_steps(8)) bus();

    sdram_phase_autotune #(
        .C_steps        (8),
        .C_settle_cycles(4),
        .C_dwell_cycles (16),
        .C_pulse_cycles (2)
    ) dut (
        .clk  (clk),
        .reset(rst),
        .bus  (bus)
    );

    int tests = 0;
    int fails = 0;

    // mem_tester model: passcount ticks every 4 cycles, failcount ticks
    // every cycle while the current phase is marked failing.
    logic [7:0] fail_mask = 8'h00;
    bit         freeze    = 1'b0;
    int         cyc       = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            bus.passcount <= '0;
            bus.failcount <= '0;
        end else begin
            if (!freeze && (cyc % 4 == 0)) bus.passcount <= bus.passcount + 1;
            if (fail_mask[bus.phase[2:0]]) bus.failcount <= bus.failcount + 1;
        end
    end

    // Pulse-shape monitor, sampled on the falling edge.
    int pulses = 0, bad_high = 0, bad_low = 0, bad_dir = 0, done_cnt = 0;
    int hi_len = 0, lo_len = 100;
    bit prev_ps = 1'b0;
    always @(negedge clk) begin
        if (bus.phasedir !== 1'b0 || bus.phaseloadreg !== 1'b0) bad_dir <= bad_dir + 1;
        if (bus.done === 1'b1) done_cnt <= done_cnt + 1;
        if (bus.phasestep === 1'b1) begin
            if (!prev_ps && lo_len < 2) bad_low <= bad_low + 1;
            hi_len <= prev_ps ? hi_len + 1 : 1;
            lo_len <= 0;
        end else begin
            if (prev_ps) pulses <= pulses + 1;
            if (prev_ps && hi_len != 2) bad_high <= bad_high + 1;
            lo_len <= lo_len + 1;
        end
        prev_ps <= (bus.phasestep === 1'b1);
    end

    task automatic do_reset();
        bus.start = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Launches a sweep and counts edges until done; optional extra starts.
    task automatic run_sweep(input logic [7:0] fmask, input bit frz, input bit extra,
                             output int cyc_n, output bit to);
        bit seen;
        fail_mask = fmask;
        freeze    = frz;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        cyc_n = 0;
        seen  = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(posedge clk);
            cyc_n++;
            #1;
            bus.start = extra && (cyc_n == 10 || cyc_n == 100 || cyc_n == 200 || cyc_n == 250);
            if (bus.done === 1'b1) seen = 1'b1;
        end
        bus.start = 1'b0;
        to = !seen;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if (bus.phasestep !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.nopass !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctl: step/busy/done/nopass=%b%b%b%b want 0000",
                     bus.phasestep, bus.busy, bus.done, bus.nopass);
        end
        tests++;
        if (bus.phase !== 8'd0 || bus.pass_map !== 8'h00 || bus.best_phase !== 8'd0 || bus.window_len !== 9'd0) begin
            fails++;
            $display("FAIL reset_data: phase=%0d map=%h best=%0d len=%0d want all 0",
                     bus.phase, bus.pass_map, bus.best_phase, bus.window_len);
        end
    endtask

    // Shared result checks for one completed sweep.
    task automatic test_result(input string nm, input logic [7:0] fmask, input bit frz,
                               input bit extra, input logic [7:0] exp_map,
                               input logic [8:0] exp_len, input logic [7:0] exp_best,
                               input bit exp_nopass, input int exp_pulses, input int exp_cyc);
        int  n, p0, bh0, bl0, bd0, d0;
        bit  to;
        do_reset();
        p0 = pulses; bh0 = bad_high; bl0 = bad_low; bd0 = bad_dir; d0 = done_cnt;
        run_sweep(fmask, frz, extra, n, to);
        tests++;
        if (to) begin
            fails++;
            $display("FAIL %s_timeout: done not seen after %0d cycles", nm, n);
        end
        tests++;
        if (bus.pass_map !== exp_map) begin
            fails++;
            $display("FAIL %s_map: got %b want %b", nm, bus.pass_map, exp_map);
        end
        tests++;
        if (bus.window_len !== exp_len || bus.best_phase !== exp_best || bus.nopass !== exp_nopass) begin
            fails++;
            $display("FAIL %s_best: len=%0d best=%0d nopass=%b want %0d %0d %b", nm,
                     bus.window_len, bus.best_phase, bus.nopass, exp_len, exp_best, exp_nopass);
        end
        tests++;
        if (bus.phase !== exp_best || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL %s_phase: phase=%0d busy=%b want %0d 0", nm, bus.phase, bus.busy, exp_best);
        end
        if (exp_cyc > 0) begin
            tests++;
            if (n != exp_cyc) begin
                fails++;
                $display("FAIL %s_latency: got %0d cycles want %0d", nm, n, exp_cyc);
            end
        end
        @(posedge clk);
        #1;
        tests++;
        if (bus.done !== 1'b0 || done_cnt - d0 != 1) begin
            fails++;
            $display("FAIL %s_done_once: done=%b count=%0d want 0 1", nm, bus.done, done_cnt - d0);
        end
        tests++;
        if (pulses - p0 != exp_pulses) begin
            fails++;
            $display("FAIL %s_pulses: got %0d want %0d", nm, pulses - p0, exp_pulses);
        end
        tests++;
        if (bad_high != bh0 || bad_low != bl0 || bad_dir != bd0) begin
            fails++;
            $display("FAIL %s_shape: bad_high=%0d bad_low=%0d bad_dir=%0d want 0 0 0", nm,
                     bad_high - bh0, bad_low - bl0, bad_dir - bd0);
        end
        // Outputs hold after completion.
        repeat (5) @(posedge clk);
        #1;
        tests++;
        if (bus.pass_map !== exp_map || bus.best_phase !== exp_best || bus.window_len !== exp_len) begin
            fails++;
            $display("FAIL %s_hold: map=%b best=%0d len=%0d", nm, bus.pass_map, bus.best_phase, bus.window_len);
        end
    endtask

    task automatic test_centre();
        test_result("centre", 8'b11000011, 1'b0, 1'b0, 8'b00111100, 9'd4, 8'd4, 1'b0, 12, 266);
    endtask

    task automatic test_wrap();
        test_result("wrap", 8'b00111100, 1'b0, 1'b0, 8'b11000011, 9'd4, 8'd0, 1'b0, 8, 241);
    endtask

    task automatic test_all_pass();
        test_result("allpass", 8'h00, 1'b0, 1'b0, 8'hFF, 9'd8, 8'd4, 1'b0, 12, 266);
    endtask

    task automatic test_tie();
        test_result("tie", 8'b10011001, 1'b0, 1'b0, 8'b01100110, 9'd2, 8'd2, 1'b0, 10, 254);
    endtask

    task automatic test_all_fail();
        test_result("allfail", 8'hFF, 1'b0, 1'b0, 8'h00, 9'd0, 8'd0, 1'b1, 8, 241);
    endtask

    task automatic test_frozen();
        test_result("frozen", 8'h00, 1'b1, 1'b0, 8'h00, 9'd0, 8'd0, 1'b1, 8, 241);
    endtask

    task automatic test_back_to_back();
        test_result("busystart", 8'b11000011, 1'b0, 1'b1, 8'b00111100, 9'd4, 8'd4, 1'b0, 12, 266);
    endtask

    task automatic test_reset_mid_pulse();
        int  rises;
        bit  prev;
        do_reset();
        fail_mask = 8'h00;
        freeze    = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        rises = 0;
        prev  = 1'b0;
        for (int i = 0; i < 3000 && rises < 3; i++) begin
            @(negedge clk);
            if (bus.phasestep === 1'b1 && !prev) rises++;
            prev = (bus.phasestep === 1'b1);
        end
        tests++;
        if (rises != 3 || bus.phase !== 8'd2 || bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL midpulse_pre: rises=%0d phase=%0d busy=%b want 3 2 1", rises, bus.phase, bus.busy);
        end
        #2 rst = 1'b1;
        #1;
        tests++;
        if (bus.phasestep !== 1'b0 || bus.busy !== 1'b0 || bus.phase !== 8'd0) begin
            fails++;
            $display("FAIL midpulse_async: step=%b busy=%b phase=%0d want 0 0 0",
                     bus.phasestep, bus.busy, bus.phase);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        tests++;
        if (bus.busy !== 1'b0 || bus.phasestep !== 1'b0) begin
            fails++;
            $display("FAIL midpulse_idle: busy=%b step=%b want 0 0", bus.busy, bus.phasestep);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        rst       = 1'b1;
        test_reset();
        test_centre();
        test_wrap();
        test_all_pass();
        test_tie();
        test_all_fail();
        test_frozen();
        test_back_to_back();
        test_reset_mid_pulse();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sdram_phase_autotune.md
Name: sdram_phase_autotune

Overview:
- Controller that sweeps the ECP5 PLL dynamic phase of the SDRAM chip clock through one full turn.
- At each phase step it checks the SDRAM mem_tester pass/fail counters over a dwell window and builds a pass map.
- It then locates the centre of the widest circular passing window and steps the PLL to that centre.
- It replaces manual BTN phase tuning.
- It drives phasedir/phasestep/phaseloadreg of the SDRAM ecp5pll, with phasesel fixed at the instance.

Parameters:
- C_steps, 8, phase steps per full PLL turn; power of 2, range 4..256.
- C_settle_cycles, 1024, clk cycles to wait after a step before sampling.
- C_dwell_cycles, 65536, clk cycles per measurement window.
- C_pulse_cycles, 4, phasestep high time; also the setup time and the low time.

Ports:
- clk  in  1  clock; same domain as mem_tester (clk_sdram).
- reset  in  1  asynchronous, active-high.
- start  in  1  single-cycle request to begin a sweep.
- passcount  in  32  from mem_tester.
- failcount  in  32  from mem_tester.
- phasedir  out  1  0 = forward step.
- phasestep  out  1  high pulse = one phase step.
- phaseloadreg  out  1  held 0.
- phase  out  8  current phase offset modulo C_steps.
- pass_map  out  C_steps  bit i = phase i passed.
- best_phase  out  8  chosen centre.
- window_len  out  9  length of the widest passing run, 0..C_steps.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse at completion.
- nopass  out  1  no phase passed; valid when done.

Behaviour:
- Reset (async): all outputs 0; phasestep deasserts immediately; FSM returns to IDLE. Phase offset restarts at 0, relative to whatever PLL state exists at reset.
- IDLE:
  - start=1 → MEASURE at offset 0; busy=1.
  - start while busy is ignored.
- Step sequence, one "step":
  - phasedir=0 throughout.
  - STEP_SETUP: C_pulse_cycles with phasestep=0.
  - STEP_PULSE: C_pulse_cycles with phasestep=1.
  - STEP_HOLD: C_pulse_cycles with phasestep=0.
  - phase increments by 1 modulo C_steps on exit from STEP_HOLD.
- MEASURE sequence:
  - SETTLE: C_settle_cycles.
  - Then latch f0=failcount and p0=passcount.
  - DWELL: C_dwell_cycles.
  - RECORD: pass_map[phase] = (failcount==f0) && (passcount!=p0). Counters compare as equal 32-bit values, so wrap is harmless.
- Sweep order:
  - MEASURE(0), then step → MEASURE(1) … MEASURE(C_steps-1).
  - One final step returns to offset 0 (total C_steps pulses). Then SCAN.
- SCAN:
  - Index k = 0..2*C_steps-1, bit = pass_map[k mod C_steps], one index per clk.
  - Run counter resets on a 0 bit.
  - A run longer than the current best (strictly greater) records best start and length. Ties are won by the earliest start.
  - Length is capped at C_steps.
  - window_len = best length.
  - best_phase = (start + window_len/2) mod C_steps, using floor.
  - All-pass gives start 0, len C_steps, best = C_steps/2.
  - No pass gives nopass=1, window_len=0, best_phase=0.
- ALIGN:
  - Issue (best_phase - phase) mod C_steps steps; phase ends equal to best_phase.
  - Zero steps if already there.
- DONE: done=1 for 1 cycle; busy=0 → IDLE.
- pass_map, best_phase, window_len and nopass hold until the next start. pass_map clears to 0 on start.
- phaseloadreg is never asserted.
- Latency:
  - Sweep = C_steps*(settle+dwell+2 + 3*pulse) + 2*C_steps + ALIGN steps*3*pulse + small constant.
  - Exact constant is fixed in RTL and documented in the header comment.

Decomposition:
- Package sdram_phase_pkg holds:
  - FSM state enum: IDLE, STEP_SETUP, STEP_PULSE, STEP_HOLD, SETTLE, DWELL, RECORD, SCAN, ALIGN, DONE.
  - Phase width constant (8).
  - Counter width function (clog2).
- One sub-module, phase_stepper:
  - Inputs: req, count.
  - Outputs: phasestep, phasedir, busy, step_done.
  - Generates the 3-segment pulse sequence, reused by both sweep and ALIGN.

Test Plan (C_steps=8, settle=4, dwell=16, pulse=2; mem_tester model increments passcount every 4 cycles and increments failcount only at selected phases):
- Failing phases 0,1,6,7 → pass_map=8'b00111100, window_len=4, best_phase=4. Exactly 8 sweep pulses + 4 align pulses; final phase=4; done pulses once; nopass=0.
- Failing phases 2..5 (wrap run 6,7,0,1) → pass_map=8'b11000011, window_len=4, best_phase=0. 0 align pulses.
- No failures → pass_map=8'hFF, window_len=8, best_phase=4. Two runs with ties (pass 1,2 and 5,6; others fail) → window_len=2, best_phase=2.
- All phases fail, or passcount frozen → pass_map=0, nopass=1, best_phase=0, phase ends 0.
- Reset asserted mid-STEP_PULSE → phasestep 0 in the same cycle (async), busy=0, phase=0. start during busy → no restart; cycle count unchanged.
- Phase pulse timing check → phasestep high exactly 2 cycles, ≥2 cycles low between pulses. phasedir=0 and phaseloadreg=0 throughout.
